lnvd_sample_delay: RTL and testbench

Parametrised multichannel sample-delay line for the LNVD ADC datapath. Each of `CHANNELS` sample streams is delayed by its own runtime-programmable number of samples, from 0 to `MAX_DELAY`, using a per-channel circular buffer. Delay is counted in accepted samples, not clocks; at 250 kHz one sample is 4000 ns. The block sits between the ADC capture stage and downstream filtering or beamforming, and it replaces the fixed 4 × 12-bit wire delay.

---
 rtl/lnvd_pkg.sv | 24 ++
 rtl/lnvd_delay_ram.sv | 24 ++
 rtl/lnvd_sample_delay.sv | 132 +++++++++++++
 tb/tb_lnvd_sample_delay.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lnvd_pkg.sv
// Shared LNVD datapath constants and helpers.
package lnvd_pkg;

  localparam int unsigned LNVD_ADC_W     = 12;
  localparam int unsigned LNVD_NUM_CH    = 4;
  localparam int unsigned LNVD_SAMPLE_NS = 4000;

  typedef logic [LNVD_ADC_W-1:0] lnvd_sample_t;

  function automatic int unsigned lnvd_clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Rounds up so a requested delay is never undershot.
  function automatic int unsigned lnvd_ns_to_samples(input int unsigned ns);
    return (ns + LNVD_SAMPLE_NS - 1) / LNVD_SAMPLE_NS;
  endfunction

endpackage

// File: rtl/lnvd_delay_ram.sv
// Per-channel delay memory: synchronous write, asynchronous read so the
// registered consumer sees the contents from before this edge's write.
module lnvd_delay_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned AW     = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lnvd_sample_delay.sv
// Multichannel sample-delay line with per-channel programmable delay.
// Optional LNVD_DELAY_PRIME_EN masks outputs until each channel's history fills.
module lnvd_sample_delay
  import lnvd_pkg::*;
#(
  parameter int unsigned CHANNELS      = LNVD_NUM_CH,
  parameter int unsigned DATA_W        = LNVD_ADC_W,
  parameter int unsigned MAX_DELAY     = 64,
  parameter int unsigned DLY_W         = lnvd_clog2(MAX_DELAY + 1),
  parameter int unsigned DEFAULT_DELAY = 50
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         cfg_load,
  input  logic [CHANNELS*DLY_W-1:0]    delay_cfg,
  output logic                         out_valid,
  output logic [CHANNELS*DATA_W-1:0]   out_data
`ifdef LNVD_DELAY_PRIME_EN
  ,
  output logic [CHANNELS-1:0]          primed
`endif
);

  localparam int unsigned AW    = (MAX_DELAY > 1) ? lnvd_clog2(MAX_DELAY) : 1;
  localparam int unsigned SUM_W = DLY_W + 1;
  localparam logic [DLY_W-1:0] DLY_MAX = DLY_W'(MAX_DELAY);
  localparam logic [DLY_W-1:0] DLY_RST =
    (DEFAULT_DELAY > MAX_DELAY) ? DLY_MAX : DLY_W'(DEFAULT_DELAY);
  localparam logic [AW-1:0] PTR_LAST = AW'(MAX_DELAY - 1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          out_valid_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (in_valid) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= in_valid;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_W-1:0] in_c, rd_data, sel, out_d, out_q;
    logic [DLY_W-1:0]  cfg_raw, cfg_clamp, dly_d, dly_q;
    logic [SUM_W-1:0]  rd_sum;
    logic [AW-1:0]     rd_addr;

    lnvd_delay_ram #(
      .DEPTH  (MAX_DELAY),
      .DATA_W (DATA_W),
      .AW     (AW)
    ) u_ram (
      .clk     (clk),
      .wr_en   (in_valid),
      .wr_addr (wr_ptr_q),
      .wr_data (in_c),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
    );

    // Read address is (wr_ptr - d) mod MAX_DELAY, formed as wr_ptr + MAX - d
    // so it never goes negative; d = MAX lands back on wr_ptr (oldest entry).
    always_comb begin
      in_c      = in_data[c*DATA_W +: DATA_W];
      cfg_raw   = delay_cfg[c*DLY_W +: DLY_W];
      cfg_clamp = (cfg_raw > DLY_MAX) ? DLY_MAX : cfg_raw;
      dly_d     = cfg_load ? cfg_clamp : dly_q;
      rd_sum    = SUM_W'(wr_ptr_q) + SUM_W'(MAX_DELAY) - SUM_W'(dly_q);
      if (rd_sum >= SUM_W'(MAX_DELAY)) rd_sum = rd_sum - SUM_W'(MAX_DELAY);
      rd_addr   = AW'(rd_sum);
      sel       = (dly_q == '0) ? in_c : rd_data;
    end

`ifdef LNVD_DELAY_PRIME_EN
    logic [DLY_W-1:0] fill_q, fill_d;
    logic             primed_now, primed_d, primed_q;

    always_comb begin
      primed_now = (fill_q >= dly_q);
      fill_d     = fill_q;
      if (cfg_load && (cfg_clamp != dly_q)) fill_d = '0;
      else if (in_valid && (fill_q != DLY_MAX)) fill_d = fill_q + DLY_W'(1);
      out_d    = out_q;
      primed_d = primed_q;
      if (in_valid) begin
        out_d    = primed_now ? sel : '0;
        primed_d = primed_now;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fill_q   <= '0;
        primed_q <= (DLY_RST == '0);
      end else begin
        fill_q   <= fill_d;
        primed_q <= primed_d;
      end
    end

    assign primed[c] = primed_q;
`else
    always_comb begin
      out_d = in_valid ? sel : out_q;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dly_q <= DLY_RST;
        out_q <= '0;
      end else begin
        dly_q <= dly_d;
        out_q <= out_d;
      end
    end

    assign out_data[c*DATA_W +: DATA_W] = out_q;
  end

endmodule

// File: tb/tb_lnvd_sample_delay.sv
// Bench for lnvd_sample_delay: vector table, hand sequences and randomized
// traffic checked against a sample-history reference model.
module tb_lnvd_sample_delay;

  localparam int unsigned CH    = 4;
  localparam int unsigned W     = 12;
  localparam int unsigned MAXD  = 64;
  localparam int unsigned DLY_W = 7;
  localparam int unsigned DEFD  = 50;
  localparam int unsigned DW    = CH * W;
`ifdef LNVD_DELAY_PRIME_EN
  localparam bit PRIME = 1'b1;
`else
  localparam bit PRIME = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              cfg_load = 1'b0;
  logic [CH*DLY_W-1:0] delay_cfg = '0;
  logic              out_valid;
  logic [DW-1:0]     out_data;
`ifdef LNVD_DELAY_PRIME_EN
  logic [CH-1:0]     primed;
`endif

  lnvd_sample_delay #(
    .CHANNELS      (CH),
    .DATA_W        (W),
    .MAX_DELAY     (MAXD),
    .DLY_W         (DLY_W),
    .DEFAULT_DELAY (DEFD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cfg_load  (cfg_load),
    .delay_cfg (delay_cfg),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef LNVD_DELAY_PRIME_EN
    ,
    .primed    (primed)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: every sample set accepted since reset, per-channel delays.
  logic [DW-1:0] hist[$];
  int unsigned   mdly [CH];
  int unsigned   mfill[CH];
  logic [W-1:0]  exp_out[CH];
  bit            exp_known[CH];
  bit            exp_primed[CH];
  bit            exp_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CH*DLY_W-1:0] rep_cfg(input int unsigned d);
    logic [CH*DLY_W-1:0] r;
    for (int c = 0; c < CH; c++) r[c*DLY_W +: DLY_W] = DLY_W'(d);
    return r;
  endfunction

  function automatic logic [DW-1:0] rep_data(input logic [W-1:0] v);
    logic [DW-1:0] r;
    for (int c = 0; c < CH; c++) r[c*W +: W] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int c = 0; c < CH; c++) begin
      mdly[c]       = (DEFD > MAXD) ? MAXD : DEFD;
      mfill[c]      = 0;
      exp_out[c]    = '0;
      exp_known[c]  = 1'b1;
      exp_primed[c] = (mdly[c] == 0);
    end
    exp_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [DW-1:0] od;
    od = out_data;
    check($sformatf("%s out_valid", tag), 64'(out_valid), 64'(exp_valid));
    for (int c = 0; c < CH; c++) begin
      if (exp_known[c])
        check($sformatf("%s out_data[%0d]", tag, c), 64'(od[c*W +: W]), 64'(exp_out[c]));
`ifdef LNVD_DELAY_PRIME_EN
      check($sformatf("%s primed[%0d]", tag, c), 64'(primed[c]), 64'(exp_primed[c]));
`endif
    end
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit ld,
                       input logic [CH*DLY_W-1:0] cfg, input string tag);
    int unsigned n, dd, nd;
    logic [DW-1:0] old;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    cfg_load  = ld;
    delay_cfg = cfg;
    n = hist.size();
    for (int c = 0; c < CH; c++) begin
      dd = mdly[c];
      if (v) begin
        if (dd == 0) begin
          exp_out[c] = d[c*W +: W]; exp_known[c] = 1'b1;
        end else if (n >= dd) begin
          old = hist[n-dd];
          exp_out[c] = old[c*W +: W]; exp_known[c] = 1'b1;
        end else begin
          exp_out[c] = '0; exp_known[c] = 1'b0;
        end
        if (PRIME) begin
          exp_primed[c] = (mfill[c] >= dd);
          if (!exp_primed[c]) begin
            exp_out[c] = '0; exp_known[c] = 1'b1;
          end
        end
      end
      nd = int'(cfg[c*DLY_W +: DLY_W]);
      if (nd > MAXD) nd = MAXD;
      if (ld && nd != dd) mfill[c] = 0;
      else if (v && mfill[c] < MAXD) mfill[c]++;
      if (ld) mdly[c] = nd;
    end
    if (v) hist.push_back(d);
    exp_valid = v;
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_load = 1'b0;
    rst_n    = 1'b1;
  endtask

  typedef struct {
    bit          v;
    logic [W-1:0] val;
    bit          ld;
    int unsigned dly;
    bit          ev;
    logic [W-1:0] ev_val;
    bit          chk;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [DW-1:0] od;
    logic [DW-1:0] zero_cfg;
    zero_cfg = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic delay of 3 on a ramp.
    tbl[0] = '{v:0, val:0, ld:1, dly:3, ev:0, ev_val:0, chk:1};
    for (int i = 1; i <= 6; i++)
      tbl[i] = '{v:1, val:W'(i), ld:0, dly:0, ev:1,
                 ev_val:(i > 3) ? W'(i - 3) : W'(0), chk:(PRIME || i > 3)};
    tbl[7] = '{v:0, val:12'hABC, ld:0, dly:0, ev:0, ev_val:3, chk:1};
    tbl[8] = '{v:1, val:7, ld:0, dly:0, ev:1, ev_val:4, chk:1};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v, rep_data(tbl[i].val), tbl[i].ld, rep_cfg(tbl[i].dly),
            $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d valid", i), 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].chk)
        check($sformatf("tbl%0d data", i), 64'(out_data), 64'(rep_data(tbl[i].ev_val)));
    end

    // Independent delays {0,1,17,64}, 200 samples so the pointer wraps.
    drive(1'b0, '0, 1'b1, {7'd64, 7'd17, 7'd1, 7'd0}, "cfg_mix");
    for (int i = 0; i < 200; i++) drive(1'b1, rnd_data(), 1'b0, zero_cfg, "mix");

    // Clamp: 100 requested on ch2, 64 on ch3.
    drive(1'b0, '0, 1'b1, {7'd64, 7'd100, 7'd2, 7'd9}, "cfg_clamp");
    for (int i = 0; i < 140; i++) drive(1'b1, rnd_data(), 1'b0, zero_cfg, "clamp");

    // Reconfiguration in the same cycle as a sample: ch0 5 -> 2.
    do_reset("rst_a");
    drive(1'b0, '0, 1'b1, rep_cfg(5), "cfg5");
    for (int i = 0; i < 8; i++) drive(1'b1, rep_data(W'(100 + i)), 1'b0, zero_cfg, "pre");
    drive(1'b1, rep_data(W'(108)), 1'b1, {7'd5, 7'd5, 7'd5, 7'd2}, "reload");
    od = out_data;
    check("reload ch0 old delay", 64'(od[W-1:0]), 64'(103));
    for (int i = 9; i < 12; i++) begin
      drive(1'b1, rep_data(W'(100 + i)), 1'b0, zero_cfg, "post");
      od = out_data;
      if (i == 11) begin
        check("post ch0 first new", 64'(od[W-1:0]), 64'(109));
        check("post ch1 unchanged", 64'(od[2*W-1:W]), 64'(106));
      end else if (PRIME) begin
        check($sformatf("post ch0 masked %0d", i), 64'(od[W-1:0]), 64'(0));
      end
    end

    // Gapped input, 1 strobe every 7 clocks.
    drive(1'b0, '0, 1'b1, {7'd3, 7'd0, 7'd12, 7'd5}, "cfg_gap");
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, rnd_data(), 1'b0, zero_cfg, "gap_v");
      repeat (6) drive(1'b0, rnd_data(), 1'b0, zero_cfg, "gap_idle");
    end

    // Mid-stream reset, then priming restarts from sample 0.
    do_reset("rst_mid");
    for (int i = 0; i < 60; i++) drive(1'b1, rnd_data(), 1'b0, zero_cfg, "after_rst");

    // Random traffic with occasional reconfiguration.
    for (int i = 0; i < 400; i++) begin
      logic [CH*DLY_W-1:0] cfg;
      for (int c = 0; c < CH; c++) cfg[c*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, 127) % 72);
      drive(($urandom_range(0, 9) < 7), rnd_data(), ($urandom_range(0, 39) == 0), cfg, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
